// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types and constants for the motor drive block
// Holds the DIR steering codes, the drive state enum, the duty type and the
// ramp step helper used by motor_drive and pwm_gen.
package motor_pkg;

  localparam int DUTY_W = 11;
  typedef logic [DUTY_W-1:0] duty_t;

  localparam logic [3:0] DIR_FWD    = 4'b0000;
  localparam logic [3:0] DIR_VEER_L = 4'b0101;
  localparam logic [3:0] DIR_VEER_R = 4'b1001;
  localparam logic [3:0] DIR_STOP   = 4'b1111;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Move cur toward tgt by at most step, landing exactly on tgt (no overshoot).
  function automatic duty_t step_toward(duty_t cur, duty_t tgt, duty_t step);
    duty_t res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) > step) ? cur + step : tgt;
    end else if (cur > tgt) begin
      res = ((cur - tgt) > step) ? cur - step : tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// rtl/motor_pwm_gen.sv - per-wheel PWM compare with period-end shadow duty
// Ports:
//   clock, reset    - system clock, synchronous active-high reset
//   cnt_next        - shared PWM counter value for the coming cycle
//   period_end      - current cycle is the last of the PWM period
//   clear           - drive is stopping: zero the shadow duty immediately
//   duty            - applied duty (sampled only at period end)
//   en_next         - channel enable for the coming cycle
//   pwm             - registered PWM output
module pwm_gen
  import motor_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  duty_t cnt_next,
  input  logic  period_end,
  input  logic  clear,
  input  duty_t duty,
  input  logic  en_next,
  output logic  pwm
);

  duty_t shadow;
  duty_t shadow_next;

  // The shadow only follows the applied duty at the period boundary so a
  // period in flight is never cut short or stretched; stopping bypasses this.
  always_comb begin
    shadow_next = shadow;
    if (clear) begin
      shadow_next = '0;
    end else if (period_end) begin
      shadow_next = duty;
    end
  end

  // The output is computed from next-cycle values so it lines up with the
  // counter and enable registers while still coming straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= '0;
      pwm    <= 1'b0;
    end else begin
      shadow <= shadow_next;
      pwm    <= en_next && (cnt_next < shadow_next);
    end
  end

endmodule

// File: rtl/motor_drive.sv
// rtl/motor_drive.sv - DIR decode, duty slew ramp and dual H-bridge PWM drive
// Ports:
//   clock, reset    - system clock, synchronous active-high reset
//   DIR             - 4-bit steering code from the line-following sensor block
//   pwm_l, pwm_r    - left/right motor PWM
//   en_l, en_r      - left/right H-bridge enable (high in RAMP and RUN)
//   moving          - either applied duty nonzero (registered)
//   at_speed        - both applied duties on target while in RUN (registered)
module motor_drive
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD = 1250,
  parameter int FULL_DUTY  = 1250,
  parameter int VEER_DUTY  = 500,
  parameter int RAMP_STEP  = 5,
  parameter int RAMP_DIV   = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] DIR,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       en_l,
  output logic       en_r,
  output logic       moving,
  output logic       at_speed
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam duty_t FULL_D = duty_t'(FULL_DUTY);
  localparam duty_t VEER_D = duty_t'(VEER_DUTY);
  localparam duty_t STEP_D = duty_t'(RAMP_STEP);
  localparam duty_t LAST_CNT = duty_t'(PWM_PERIOD - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(RAMP_DIV - 1);

  logic [3:0]       dir_q;
  state_t           state, state_next;
  duty_t            duty_l, duty_r, duty_l_next, duty_r_next;
  duty_t            tgt_l, tgt_r;
  duty_t            cnt, cnt_next;
  logic [DIV_W-1:0] div_cnt;
  logic             stop_req, tick, period_end, en_next, stopping;

  // Decode: anything other than the three drive codes is a stop request.
  always_comb begin
    stop_req = 1'b0;
    tgt_l    = '0;
    tgt_r    = '0;
    case (dir_q)
      DIR_FWD:    begin tgt_l = FULL_D; tgt_r = FULL_D; end
      DIR_VEER_L: begin tgt_l = VEER_D; tgt_r = FULL_D; end
      DIR_VEER_R: begin tgt_l = FULL_D; tgt_r = VEER_D; end
      default:    stop_req = 1'b1;
    endcase
  end

  assign tick       = (state == RAMP) && (div_cnt == LAST_DIV);
  assign period_end = (cnt == LAST_CNT);
  assign cnt_next   = period_end ? '0 : cnt + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      STOP:    state_next = RAMP;
      RAMP:    if (duty_l == tgt_l && duty_r == tgt_r) state_next = RUN;
      RUN:     if (duty_l != tgt_l || duty_r != tgt_r) state_next = RAMP;
      default: state_next = STOP;
    endcase
    // Stop is never ramped: it overrides every state transition.
    if (stop_req) state_next = STOP;
  end

  assign stopping = (state_next == STOP);
  assign en_next  = !stopping;

  always_comb begin
    duty_l_next = duty_l;
    duty_r_next = duty_r;
    if (stopping) begin
      duty_l_next = '0;
      duty_r_next = '0;
    end else if (tick) begin
      duty_l_next = step_toward(duty_l, tgt_l, STEP_D);
      duty_r_next = step_toward(duty_r, tgt_r, STEP_D);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q    <= DIR_STOP;
      state    <= STOP;
      duty_l   <= '0;
      duty_r   <= '0;
      cnt      <= '0;
      div_cnt  <= '0;
      en_l     <= 1'b0;
      en_r     <= 1'b0;
      moving   <= 1'b0;
      at_speed <= 1'b0;
    end else begin
      dir_q  <= DIR;
      state  <= state_next;
      duty_l <= duty_l_next;
      duty_r <= duty_r_next;
      cnt    <= cnt_next;
      // Divider restarts on every entry to RAMP so the first step is a full
      // tick after the target change.
      if (state_next == RAMP && state != RAMP) begin
        div_cnt <= '0;
      end else if (state == RAMP) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
      end
      en_l     <= en_next;
      en_r     <= en_next;
      // Status follows the duties a cycle late, except a stop drops it at once.
      moving   <= !stopping && (duty_l != '0 || duty_r != '0);
      at_speed <= (state_next == RUN) && (duty_l == tgt_l) && (duty_r == tgt_r);
    end
  end

  pwm_gen u_pwm_l (
    .clock      (clock),
    .reset      (reset),
    .cnt_next   (cnt_next),
    .period_end (period_end),
    .clear      (stopping),
    .duty       (duty_l),
    .en_next    (en_next),
    .pwm        (pwm_l)
  );

  pwm_gen u_pwm_r (
    .clock      (clock),
    .reset      (reset),
    .cnt_next   (cnt_next),
    .period_end (period_end),
    .clear      (stopping),
    .duty       (duty_r),
    .en_next    (en_next),
    .pwm        (pwm_r)
  );

endmodule

// File: tb/tb_motor_drive.sv
// tb/tb_motor_drive.sv - directed table-driven bench for motor_drive
module tb_motor_drive;

  logic       clock;
  logic       reset;
  logic [3:0] DIR;
  logic       pwm_l, pwm_r, en_l, en_r, moving, at_speed;

  motor_drive #(
    .PWM_PERIOD (10),
    .FULL_DUTY  (10),
    .VEER_DUTY  (4),
    .RAMP_STEP  (2),
    .RAMP_DIV   (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .DIR      (DIR),
    .pwm_l    (pwm_l),
    .pwm_r    (pwm_r),
    .en_l     (en_l),
    .en_r     (en_r),
    .moving   (moving),
    .at_speed (at_speed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // exp = {pwm_l, pwm_r, en_l, en_r, moving, at_speed}
  // kind 0: hold n edges then compare once; kind 1: compare after every edge
  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] dir;
    int         n;
    int         kind;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string name, logic rst, logic [3:0] dir, int n,
                              int kind, logic [5:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.dir = dir; v.n = n; v.kind = kind; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {pwm_l, pwm_r, en_l, en_r, moving, at_speed};
  endfunction

  task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b (pl pr el er mv at)", name, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    DIR   = 4'b1111;

    tbl.push_back(mk("reset",        1, 4'hF, 3, 0, 6'b000000));
    // 1: forward from stop, ramp 0..10 every 3 cycles, then steady full on
    tbl.push_back(mk("t1_dirq",      0, 4'h0, 1, 0, 6'b000000));
    tbl.push_back(mk("t1_ramp_en",   0, 4'h0, 1, 0, 6'b001100));
    tbl.push_back(mk("t1_tick1",     0, 4'h0, 3, 0, 6'b001100));
    tbl.push_back(mk("t1_moving",    0, 4'h0, 1, 0, 6'b001110));
    tbl.push_back(mk("t1_pulse4_hi", 0, 4'h0, 4, 0, 6'b111110));
    tbl.push_back(mk("t1_pulse4_lo", 0, 4'h0, 4, 0, 6'b001110));
    tbl.push_back(mk("t1_at_speed",  0, 4'h0, 4, 0, 6'b001111));
    tbl.push_back(mk("t1_full_on",   0, 4'h0, 3, 0, 6'b111111));
    tbl.push_back(mk("t1_steady",    0, 4'h0, 20, 1, 6'b111111));
    // 2: veer left, left ramps 10 -> 4, right held at full
    tbl.push_back(mk("t2_dirq",      0, 4'h5, 1, 0, 6'b111111));
    tbl.push_back(mk("t2_ramp",      0, 4'h5, 1, 0, 6'b111110));
    tbl.push_back(mk("t2_run",       0, 4'h5, 10, 0, 6'b111111));
    tbl.push_back(mk("t2_per_start", 0, 4'h5, 7, 0, 6'b111111));
    tbl.push_back(mk("t2_high_end",  0, 4'h5, 3, 0, 6'b111111));
    tbl.push_back(mk("t2_low_start", 0, 4'h5, 1, 0, 6'b011111));
    tbl.push_back(mk("t2_low_end",   0, 4'h5, 5, 0, 6'b011111));
    tbl.push_back(mk("t2_next_per",  0, 4'h5, 1, 0, 6'b111111));
    // 3: veer left -> veer right, wheels cross
    tbl.push_back(mk("t3_dirq",      0, 4'h9, 1, 0, 6'b111111));
    tbl.push_back(mk("t3_ramp",      0, 4'h9, 1, 0, 6'b111110));
    tbl.push_back(mk("t3_last_tick", 0, 4'h9, 9, 0, 6'b111110));
    tbl.push_back(mk("t3_run",       0, 4'h9, 1, 0, 6'b111111));
    tbl.push_back(mk("t3_mid_8_6",   0, 4'h9, 5, 0, 6'b101111));
    tbl.push_back(mk("t3_new_per",   0, 4'h9, 3, 0, 6'b111111));
    tbl.push_back(mk("t3_r_low",     0, 4'h9, 4, 0, 6'b101111));
    // 4: back to veer left, stop mid-ramp with left at 6
    tbl.push_back(mk("t4_midramp",   0, 4'h5, 8, 0, 6'b111110));
    tbl.push_back(mk("t4_dirq",      0, 4'hF, 1, 0, 6'b111110));
    tbl.push_back(mk("t4_stop",      0, 4'hF, 1, 0, 6'b000000));
    tbl.push_back(mk("t4_stop_hold", 0, 4'hF, 5, 1, 6'b000000));
    // 5: forward to RUN, illegal code stops, forward restarts from 0
    tbl.push_back(mk("t5_run",       0, 4'h0, 18, 0, 6'b001111));
    tbl.push_back(mk("t5_ill_dirq",  0, 4'h3, 1, 0, 6'b001111));
    tbl.push_back(mk("t5_ill_stop",  0, 4'h3, 1, 0, 6'b000000));
    tbl.push_back(mk("t5_re_dirq",   0, 4'h0, 1, 0, 6'b000000));
    tbl.push_back(mk("t5_re_ramp",   0, 4'h0, 1, 0, 6'b001100));
    tbl.push_back(mk("t5_from_zero", 0, 4'h0, 3, 0, 6'b001100));
    tbl.push_back(mk("t5_step1",     0, 4'h0, 1, 0, 6'b001110));
    tbl.push_back(mk("t5_full",      0, 4'h0, 29, 0, 6'b111111));
    // 6: reset while pulsing, restart waits for tick 1 and period end
    tbl.push_back(mk("t6_pulsing",   0, 4'h0, 5, 0, 6'b111111));
    tbl.push_back(mk("t6_reset",     1, 4'h0, 1, 0, 6'b000000));
    tbl.push_back(mk("t6_no_pulse",  0, 4'h0, 9, 0, 6'b001110));
    tbl.push_back(mk("t6_first",     0, 4'h0, 1, 0, 6'b111110));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      DIR   = tbl[i].dir;
      if (tbl[i].kind == 0) begin
        repeat (tbl[i].n) @(posedge clock);
        #1;
        chk(tbl[i].name, outs(), tbl[i].exp);
      end else begin
        for (int k = 0; k < tbl[i].n; k++) begin
          @(posedge clock);
          #1;
          chk(tbl[i].name, outs(), tbl[i].exp);
        end
      end
    end

    // Steady veer left from reset: left 4 of 10 high, right always high.
    begin
      int cyc;
      int hl;
      int hr;
      reset = 1'b1;
      DIR   = 4'h5;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      cyc = 0;
      while (!at_speed && cyc < 200) begin
        @(posedge clock);
        #1;
        cyc++;
      end
      chk_int("veer_at_speed_reached", int'(at_speed), 1);
      repeat (12) @(posedge clock);
      #1;
      hl = 0;
      hr = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clock);
        #1;
        hl += int'(pwm_l);
        hr += int'(pwm_r);
      end
      chk_int("veer_left_high_count", hl, 4);
      chk_int("veer_right_high_count", hr, 10);

      // Stop: duty 0 means constantly low and enables off.
      DIR = 4'hF;
      repeat (2) @(posedge clock);
      #1;
      hl = 0;
      hr = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clock);
        #1;
        hl += int'(pwm_l) + int'(en_l);
        hr += int'(pwm_r) + int'(en_r);
      end
      chk_int("stop_left_activity", hl, 0);
      chk_int("stop_right_activity", hr, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_drive.md
Name: motor_drive

Overview:
- Consumer of the 4-bit DIR steering code produced by the line-following sensor block.
- Decodes DIR into per-wheel target duty and ramps each wheel's applied duty toward its target at a fixed slew rate.
- Generates glitch-free PWM and enable signals for the left and right H-bridge channels.
- Sits between the steering logic and the motor driver pins. STOP and illegal codes cut drive immediately.

Parameters:
- PWM_PERIOD, 1250: PWM period in clock cycles; 20 kHz at 25 MHz.
- DUTY_W, 11: width of duty and PWM counter; must satisfy 2^DUTY_W > PWM_PERIOD.
- FULL_DUTY, 1250: target duty for a wheel at full speed; must be ≤ PWM_PERIOD.
- VEER_DUTY, 500: target duty for the inner wheel when veering.
- RAMP_STEP, 5: maximum duty change per ramp tick.
- RAMP_DIV, 25000: clock cycles per ramp tick (1 ms).

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- DIR, input, 4: steering code. 0000 = forward, 0101 = veer left, 1001 = veer right, 1111 = stop, others illegal.
- pwm_l, output, 1: left motor PWM.
- pwm_r, output, 1: right motor PWM.
- en_l, output, 1: left H-bridge enable.
- en_r, output, 1: right H-bridge enable.
- moving, output, 1: high when either applied duty is nonzero.
- at_speed, output, 1: high when both applied duties equal their targets and the state is RUN.

Behaviour:
- Reset, on any clock edge with reset high:
  - All outputs go to 0.
  - Applied duties, PWM counter and ramp divider go to 0.
  - State goes to STOP.
  - Reset mid-ramp or mid-period aborts immediately, with no partial pulse afterward.
- DIR is registered once (dir_q); all decode uses dir_q. Decode is complete one cycle after a DIR change.
- Targets (left/right):
  - 0000: FULL/FULL.
  - 0101: VEER/FULL.
  - 1001: FULL/VEER.
  - 1111 or any illegal code: stop.
- States:
  - STOP: applied duties are forced to 0; en_l = en_r = 0; outputs held low. A legal non-stop code moves the state to RAMP on the next cycle.
  - RAMP: on each ramp tick (divider reaches RAMP_DIV-1, then wraps to 0), each applied duty moves toward its target by min(RAMP_STEP, |target−applied|). There is no overshoot; arithmetic saturates at 0 and FULL_DUTY. When both applied duties equal their targets, the state moves to RUN.
  - RUN: duties are held. A change of target returns the state to RAMP. A stop or illegal code moves the state to STOP.
- From any state, a stop or illegal code gives STOP on the next cycle, with applied duty 0 and en low in the same cycle. Stop is never ramped.
- The ramp divider runs only in RAMP and is cleared on entry to RAMP.
- Veer transitions (e.g. 0101 → 1001) ramp each wheel independently; one wheel may rise while the other falls.
- PWM:
  - Counter runs 0 .. PWM_PERIOD-1 and wraps.
  - pwm_x = (counter < shadow_duty_x) and en_x.
  - Shadow duty loads from applied duty only when counter = PWM_PERIOD-1, so there are no mid-period glitches. The exception is STOP, which zeroes shadow duty at once.
  - Duty 0 gives output constantly low. Duty PWM_PERIOD gives output constantly high.
- en_x is high in RAMP and RUN.
- moving and at_speed are registered and update one cycle after the applied-duty change.
- Simultaneous ramp tick and period end: the applied-duty update wins; the shadow load samples the old applied value.

Decomposition:
- Shared package motor_pkg holds:
  - DIR code constants DIR_FWD, DIR_VEER_L, DIR_VEER_R, DIR_STOP.
  - State enum STOP/RAMP/RUN.
  - Duty type width DUTY_W.
- One sub-module, pwm_gen, instantiated twice. It holds the counter compare, shadow register and period-end load.
  - Alternatively one shared counter feeds two compare instances. The single-counter variant is required so that both wheels are phase-aligned.

Test Plan:
Simulation parameters: PWM_PERIOD=10, FULL_DUTY=10, VEER_DUTY=4, RAMP_STEP=2, RAMP_DIV=3.
1. Reset, then DIR=0000 → STOP to RAMP. Applied duties go 0, 2, 4, 6, 8, 10 every 3 cycles; RUN is entered; at_speed=1; pwm_l and pwm_r stay constantly high.
2. From RUN at full speed, DIR=0101 → left duty ramps 10, 8, 6, 4 while right stays 10. pwm_l shows 4-high/6-low periods after the next period boundary.
3. Veer left at steady state, then DIR=1001 → left rises 4 to 10 and right falls 10 to 4 concurrently; at_speed asserts when both reach target.
4. Mid-ramp (left=6), DIR=1111 → next cycle en_l=en_r=0, pwm low, moving=0, state STOP.
5. DIR=0011 (illegal) while in RUN → treated as stop, with the same response as test 4. Then DIR=0000 → ramp restarts from 0.
6. Assert reset mid-period with pwm high → outputs 0 on that edge. After release with DIR=0000, the first pulse appears only after ramp tick 1 and the following period boundary.
